// File: rtl/serial_router_pkg.sv
// serial_router_pkg: shared FSM state encodings and error codes for the serial packet router.
// Optional build macro: SERIAL_ROUTER_PARITY_EN selects how error code 3 is used
// (parity failure when defined, illegal port when undefined).
package serial_router_pkg;

  // FSM state encoding kept as plain constants so older tools and netlists see fixed codes.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_PORT = 3'd1;
  localparam state_t ST_LEN  = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_PAR  = 3'd4;
  localparam state_t ST_STOP = 3'd5;

  // Error cause reported alongside frame_err.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_LEN0     = 2'd1,
    ERR_STOP     = 2'd2,
    ERR_PORT_PAR = 2'd3
  } err_t;

  // Code 3 is shared: parity failure owns it when parity is built in, so an
  // illegal port then falls back to the stop-error code.
  localparam err_t ERR_PAR = ERR_PORT_PAR;
`ifdef SERIAL_ROUTER_PARITY_EN
  localparam err_t ERR_PORT = ERR_STOP;
`else
  localparam err_t ERR_PORT = ERR_PORT_PAR;
`endif

endpackage

// File: rtl/serial_shift_in.sv
// serial_shift_in: 8-bit MSB-first deserialiser. Shifts one bit per enabled clock
// and presents the completed byte with a one-cycle byte_done strobe on the cycle
// after the 8th bit is sampled.
module serial_shift_in (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] byte_data,
  output logic       byte_done
);

  // Only the first seven bits need storing; the eighth goes straight to the output byte.
  logic [6:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;

  // Next-state: shift while enabled, publish the byte when the bit counter wraps.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (clr) begin
      cnt_d = 3'd0;
    end else if (en) begin
      shift_d = {shift_q[5:0], bit_in};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        data_d = {shift_q, bit_in};
        done_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign byte_data = data_q;
  assign byte_done = done_q;

endmodule

// File: rtl/serial_packet_router.sv
// serial_packet_router: receives one-bit-per-clock framed packets
//   0 start | port | len | len*8 data | [parity] | 1 stop   (all MSB first)
// and emits payload bytes tagged with their destination port, plus frame
// completion / classified error pulses.
// Optional build macro: SERIAL_ROUTER_PARITY_EN adds an even-parity bit after
// the payload, checked before the stop bit.
module serial_packet_router
  import serial_router_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS),
  parameter int LEN_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_in,
  output logic              frame_active,
  output logic [PORT_W-1:0] port_out,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic [PORT_W-1:0] byte_port,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code
);

  // Header field shifter only needs to be as wide as the wider header field.
  localparam int FW = (PORT_W > LEN_W) ? PORT_W : LEN_W;
  localparam logic [2:0] PORT_LAST = 3'(PORT_W - 1);
  localparam logic [2:0] LEN_LAST  = 3'(LEN_W - 1);

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [FW-1:0]       field_sr_q, field_sr_d;
  logic [PORT_W-1:0]   port_q, port_d;
  logic                active_q, active_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  err_t                err_code_q, err_code_d;
  // Cleared after an illegal port so the rest of that frame cannot look like a start bit.
  logic                armed_q, armed_d;
`ifdef SERIAL_ROUTER_PARITY_EN
  logic                par_q, par_d;
`endif

  logic [PORT_W-1:0]   port_val;
  logic [LEN_W-1:0]    len_val;
  logic                shift_en;

  // Frame decoder: walks the fields, captures port/length and classifies errors.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    field_sr_d = {field_sr_q[FW-2:0], ser_in};
    port_d     = port_q;
    active_d   = active_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    armed_d    = armed_q;
`ifdef SERIAL_ROUTER_PARITY_EN
    par_d      = par_q;
`endif
    port_val   = field_sr_d[PORT_W-1:0];
    len_val    = field_sr_d[LEN_W-1:0];
    shift_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 3'd0;
        if (armed_q && !ser_in) begin
          state_d  = ST_PORT;
          active_d = 1'b1;
        end else if (ser_in) begin
          armed_d = 1'b1;
        end
      end
      ST_PORT: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == PORT_LAST) begin
          bit_cnt_d = 3'd0;
          if (int'(port_val) >= NUM_PORTS) begin
            state_d    = ST_IDLE;
            active_d   = 1'b0;
            err_d      = 1'b1;
            err_code_d = ERR_PORT;
            armed_d    = 1'b0;
          end else begin
            port_d  = port_val;
            state_d = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == LEN_LAST) begin
          bit_cnt_d = 3'd0;
          if (len_val == '0) begin
            state_d    = ST_IDLE;
            active_d   = 1'b0;
            err_d      = 1'b1;
            err_code_d = ERR_LEN0;
          end else begin
            byte_cnt_d = len_val;
            state_d    = ST_DATA;
`ifdef SERIAL_ROUTER_PARITY_EN
            par_d      = 1'b0;
`endif
          end
        end
      end
      ST_DATA: begin
        shift_en  = 1'b1;
        bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef SERIAL_ROUTER_PARITY_EN
        par_d     = par_q ^ ser_in;
`endif
        if (bit_cnt_q == 3'd7) begin
          byte_cnt_d = byte_cnt_q - 1'b1;
          if (byte_cnt_q == LEN_W'(1)) begin
`ifdef SERIAL_ROUTER_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_ROUTER_PARITY_EN
      ST_PAR: begin
        // Even parity: the received bit must equal the XOR of every payload bit.
        if (ser_in != par_q) begin
          state_d    = ST_IDLE;
          active_d   = 1'b0;
          err_d      = 1'b1;
          err_code_d = ERR_PAR;
        end else begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        state_d  = ST_IDLE;
        active_d = 1'b0;
        if (ser_in) begin
          done_d = 1'b1;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_STOP;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  // Decoder state and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      field_sr_q <= '0;
      port_q     <= '0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      armed_q    <= 1'b1;
`ifdef SERIAL_ROUTER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      field_sr_q <= field_sr_d;
      port_q     <= port_d;
      active_q   <= active_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      armed_q    <= armed_d;
`ifdef SERIAL_ROUTER_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  serial_shift_in u_shift (
    .clk       (clk),
    .reset     (reset),
    .clr       (state_q != ST_DATA),
    .en        (shift_en),
    .bit_in    (ser_in),
    .byte_data (byte_data),
    .byte_done (byte_valid)
  );

  assign frame_active = active_q;
  assign port_out     = port_q;
  assign byte_port    = port_q;
  assign frame_done   = done_q;
  assign frame_err    = err_q;
  assign err_code     = err_code_q;

endmodule
